ip_loop_sequencer: RTL and testbench
====================================

// Module: ip_loop_sequencer
// PURPOSE
//  Instruction-pointer line with bracket-matching loop lookup; sits between the core sequencer and program ROM.
//  Holds a BCD IP and a BCD loop-depth counter, both modelling dekatron step timing.
//  On Request, advances IP (forward/backward), skips to the matching bracket when a jump is taken, and presents the next Insn.
//  Adds over previous generation: external ROM handshake, absolute IP load, unmatched-bracket/depth-overflow error.
// PARAMETERS
//  IP_DIGITS      6     BCD digits of IP (range 0..10^IP_DIGITS-1)
//  LOOP_DIGITS    3     BCD digits of loop-depth counter
//  INSN_WIDTH     4     instruction width
//  STEP_DELAY     3     cycles per counter step (IP or depth), >=1
//  OPC_LOOP_OPEN  4'h6  '[' opcode
//  OPC_LOOP_CLOSE 4'h7  ']' opcode
// PORTS
//  Clk          in   1               clock, posedge
//  Rst_n        in   1               async reset, active low
//  Request      in   1               level; start step when Ready & IDLE
//  Ready        out  1               1 in IDLE or READY
//  DataIsZeroed in   1               current data cell == 0, sampled at Request accept
//  Load         in   1               with Request: IP <= LoadAddr, no step
//  LoadAddr     in   IP_DIGITS*4     BCD load address
//  Insn         out  INSN_WIDTH      current instruction (registered)
//  IpAddr       out  IP_DIGITS*4     current BCD IP
//  LoopDepth    out  LOOP_DIGITS*4   current BCD depth (0 when not in lookup)
//  RomReq       out  1               one-cycle fetch pulse
//  RomAddr      out  IP_DIGITS*4     = IpAddr
//  RomData      in   INSN_WIDTH      valid when RomReady
//  RomReady     in   1               fetch done; may assert >=1 cycle after RomReq
//  Error        out  1               sticky fault flag
// BEHAVIOUR
//  Reset: IpAddr=0, LoopDepth=0, Insn=0, RomReq=0, Error=0, Primed=0, state IDLE (Ready=1). Async, any state.
//  States: IDLE, STEP, FETCH, DEPTH, READY, ERROR. Ready = IDLE|READY.
//  IDLE & Request: Load=1 -> IpAddr<=LoadAddr, Primed<=1, FETCH, lookup off.
//    Primed=0 -> Primed<=1, FETCH at current IP (no step).
//    else dir_back = (Insn==CLOSE)&~DataIsZeroed; jump = (Insn==OPEN)&DataIsZeroed | dir_back;
//    jump -> LoopDepth<=1 (takes STEP_DELAY in DEPTH, then STEP); else STEP. dir_back latched for whole op.
//  STEP: STEP_DELAY cycles, then IpAddr +1 (fwd) / -1 (back), BCD per digit; -> FETCH.
//  FETCH: RomReq=1 on entry cycle only; wait RomReady, latch RomData as tmp.
//    LoopDepth==0 -> Insn<=tmp, READY.
//    tmp is bracket: closing-for-direction (fwd ']' / back '[') -> depth-1, else depth+1; DEPTH.
//    tmp not bracket -> STEP.
//  DEPTH: STEP_DELAY cycles; then depth==0 -> Insn<=tmp (matching bracket), READY; else STEP.
//  READY: hold outputs; Request low -> IDLE. Min Request-to-Ready: STEP_DELAY+2 cycles + ROM latency.
//  Wrap: outside lookup IP wraps 999999->0 / 0->999999 silently.
//    During lookup (depth!=0) a wrap, or depth increment past all-9s -> ERROR.
//  ERROR: Error=1, Ready=0, RomReq=0, Request ignored; exit only by reset.
//  Load during lookup impossible (only sampled in IDLE). RomReady outside FETCH ignored.
//  DataIsZeroed ignored after accept; Insn changes only on READY entry.
// TESTING
//  Reset, Request, ROM {0:'+'} -> FETCH addr 0, no step, Insn='+', IpAddr=0, Ready after ROM latency+1.
//  Prog "+[-]>" fetch 1 ('['), DataIsZeroed=1, Request -> IP skips to 3, Insn=']', LoopDepth 1->0, then Request -> IP=4 '>'.
//  Prog "[[-]]+" at IP=4 ']', DataIsZeroed=0 -> backward lookup, depth 1->2->1->0, IP=0, Insn='['.
//  Load LoadAddr=BCD 000129 -> IpAddr=000129, Insn=ROM[129]; next Request -> IpAddr=000130 (BCD carry).
//  IP=999999 non-bracket, Request -> IpAddr=0 no Error; '[' at 999998 zeroed w/o ']' -> wrap -> Error=1, Ready=0.
//  LOOP_DIGITS=1, ten nested '[' during fwd lookup -> depth>9 -> Error=1; Rst_n low mid-STEP -> all reset values.

Source files
------------

// File: rtl/ip_loop_sequencer_if.sv
// Sequencer/ROM bundle for the loop-aware instruction-pointer line.
// master = core sequencer plus program ROM, slave = ip_loop_sequencer.
interface ip_loop_sequencer_if #(
  parameter int IP_DIGITS   = 6,
  parameter int LOOP_DIGITS = 3,
  parameter int INSN_WIDTH  = 4
);
  logic                     Request;
  logic                     Ready;
  logic                     DataIsZeroed;
  logic                     Load;
  logic [IP_DIGITS*4-1:0]   LoadAddr;
  logic [INSN_WIDTH-1:0]    Insn;
  logic [IP_DIGITS*4-1:0]   IpAddr;
  logic [LOOP_DIGITS*4-1:0] LoopDepth;
  logic                     RomReq;
  logic [IP_DIGITS*4-1:0]   RomAddr;
  logic [INSN_WIDTH-1:0]    RomData;
  logic                     RomReady;
  logic                     Error;

  modport master (
    output Request, DataIsZeroed, Load, LoadAddr,
    output RomData, RomReady,
    input  Ready, Insn, IpAddr, LoopDepth,
    input  RomReq, RomAddr, Error
  );

  modport slave (
    input  Request, DataIsZeroed, Load, LoadAddr,
    input  RomData, RomReady,
    output Ready, Insn, IpAddr, LoopDepth,
    output RomReq, RomAddr, Error
  );
endinterface

// File: rtl/ip_loop_sequencer.sv
// BCD instruction pointer with dekatron-paced stepping and
// bracket-matching loop lookup in front of an external program ROM.
module ip_loop_sequencer #(
  parameter int IP_DIGITS   = 6,
  parameter int LOOP_DIGITS = 3,
  parameter int INSN_WIDTH  = 4,
  parameter int STEP_DELAY  = 3,
  parameter logic [INSN_WIDTH-1:0] OPC_LOOP_OPEN  = 4'h6,
  parameter logic [INSN_WIDTH-1:0] OPC_LOOP_CLOSE = 4'h7
) (
  input logic Clk,
  input logic Rst_n,
  ip_loop_sequencer_if.slave bus
);
  localparam int IPW = IP_DIGITS * 4;
  localparam int LDW = LOOP_DIGITS * 4;
  localparam int CW  = (STEP_DELAY > 1) ? $clog2(STEP_DELAY) : 1;
  localparam logic [CW-1:0] LAST = CW'(STEP_DELAY - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_STEP, S_FETCH, S_DEPTH, S_READY, S_ERROR
  } state_t;

  state_t                state;
  logic [IPW-1:0]        ip;
  logic [LDW-1:0]        depth;
  logic [INSN_WIDTH-1:0] insn;
  logic [INSN_WIDTH-1:0] tmp;
  logic [CW-1:0]         cnt;
  logic                  rom_req;
  logic                  primed;
  logic                  back;

  // Returns {wrap, value}: one BCD step up or down with ripple.
  function automatic logic [IPW:0] ip_next(
    input logic [IPW-1:0] v,
    input logic           dn
  );
    logic [IPW-1:0] r;
    logic [3:0]     d;
    logic           c;
    r = v;
    c = 1'b1;
    for (int i = 0; i < IP_DIGITS; i++) begin
      d = v[4*i +: 4];
      if (c) begin
        if (dn) begin
          c = (d == 4'd0);
          r[4*i +: 4] = c ? 4'd9 : d - 4'd1;
        end else begin
          c = (d == 4'd9);
          r[4*i +: 4] = c ? 4'd0 : d + 4'd1;
        end
      end
    end
    return {c, r};
  endfunction

  function automatic logic [LDW:0] dep_next(
    input logic [LDW-1:0] v,
    input logic           dn
  );
    logic [LDW-1:0] r;
    logic [3:0]     d;
    logic           c;
    r = v;
    c = 1'b1;
    for (int i = 0; i < LOOP_DIGITS; i++) begin
      d = v[4*i +: 4];
      if (c) begin
        if (dn) begin
          c = (d == 4'd0);
          r[4*i +: 4] = c ? 4'd9 : d - 4'd1;
        end else begin
          c = (d == 4'd9);
          r[4*i +: 4] = c ? 4'd0 : d + 4'd1;
        end
      end
    end
    return {c, r};
  endfunction

  logic           rom_open;
  logic           rom_close;
  logic           closing;
  logic           jmp_back;
  logic           jmp;
  logic [IPW:0]   ip_nx;
  logic [LDW:0]   d_nx;

  assign rom_open  = bus.RomData == OPC_LOOP_OPEN;
  assign rom_close = bus.RomData == OPC_LOOP_CLOSE;
  assign closing   = back ? rom_open : rom_close;
  assign jmp_back  = (insn == OPC_LOOP_CLOSE) & ~bus.DataIsZeroed;
  assign jmp       = ((insn == OPC_LOOP_OPEN) & bus.DataIsZeroed)
                   | jmp_back;
  assign ip_nx     = ip_next(ip, back);
  assign d_nx      = dep_next(depth, closing);

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state   <= S_IDLE;
      ip      <= '0;
      depth   <= '0;
      insn    <= '0;
      tmp     <= '0;
      cnt     <= '0;
      rom_req <= 1'b0;
      primed  <= 1'b0;
      back    <= 1'b0;
    end else begin
      rom_req <= 1'b0;
      unique case (state)
        S_IDLE: if (bus.Request) begin
          cnt <= '0;
          if (bus.Load) begin
            ip      <= bus.LoadAddr;
            depth   <= '0;
            primed  <= 1'b1;
            rom_req <= 1'b1;
            state   <= S_FETCH;
          end else if (!primed) begin
            primed  <= 1'b1;
            rom_req <= 1'b1;
            state   <= S_FETCH;
          end else begin
            back <= jmp_back;
            if (jmp) begin
              depth <= LDW'(1);
              state <= S_DEPTH;
            end else begin
              state <= S_STEP;
            end
          end
        end
        S_STEP: begin
          if (cnt == LAST) begin
            cnt <= '0;
            if (ip_nx[IPW] && depth != '0) begin
              state <= S_ERROR;
            end else begin
              ip      <= ip_nx[IPW-1:0];
              rom_req <= 1'b1;
              state   <= S_FETCH;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        // The ROM answers no earlier than the cycle after the pulse.
        S_FETCH: if (bus.RomReady && !rom_req) begin
          tmp <= bus.RomData;
          cnt <= '0;
          if (depth == '0) begin
            insn  <= bus.RomData;
            state <= S_READY;
          end else if (rom_open || rom_close) begin
            if (!closing && d_nx[LDW]) begin
              state <= S_ERROR;
            end else begin
              depth <= d_nx[LDW-1:0];
              state <= S_DEPTH;
            end
          end else begin
            state <= S_STEP;
          end
        end
        S_DEPTH: begin
          if (cnt == LAST) begin
            cnt <= '0;
            if (depth == '0) begin
              insn  <= tmp;
              state <= S_READY;
            end else begin
              state <= S_STEP;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        S_READY: if (!bus.Request) state <= S_IDLE;
        S_ERROR: state <= S_ERROR;
        default: state <= S_ERROR;
      endcase
    end
  end

  assign bus.Ready     = (state == S_IDLE) || (state == S_READY);
  assign bus.Error     = state == S_ERROR;
  assign bus.Insn      = insn;
  assign bus.IpAddr    = ip;
  assign bus.RomAddr   = ip;
  assign bus.LoopDepth = depth;
  assign bus.RomReq    = rom_req;
endmodule

// File: tb/tb_ip_loop_sequencer.sv
// Scoreboard bench for ip_loop_sequencer: directed programs,
// expected Insn/IpAddr queued at issue, checked on Ready rise.
module tb_ip_loop_sequencer;
  localparam int SD  = 3;
  localparam int LAT = 2;
  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_INC = 4'h1;
  localparam logic [3:0] OP_DEC = 4'h2;
  localparam logic [3:0] OP_RGT = 4'h3;
  localparam logic [3:0] OP_OUT = 4'h5;
  localparam logic [3:0] OP_OPN = 4'h6;
  localparam logic [3:0] OP_CLS = 4'h7;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ip_loop_sequencer_if #(.IP_DIGITS(6), .LOOP_DIGITS(3),
                         .INSN_WIDTH(4)) b1 ();
  ip_loop_sequencer_if #(.IP_DIGITS(6), .LOOP_DIGITS(1),
                         .INSN_WIDTH(4)) b2 ();

  ip_loop_sequencer #(
    .IP_DIGITS(6), .LOOP_DIGITS(3), .INSN_WIDTH(4),
    .STEP_DELAY(SD), .OPC_LOOP_OPEN(OP_OPN),
    .OPC_LOOP_CLOSE(OP_CLS)
  ) dut1 (.Clk(clk), .Rst_n(rst_n), .bus(b1));

  ip_loop_sequencer #(
    .IP_DIGITS(6), .LOOP_DIGITS(1), .INSN_WIDTH(4),
    .STEP_DELAY(SD), .OPC_LOOP_OPEN(OP_OPN),
    .OPC_LOOP_CLOSE(OP_CLS)
  ) dut2 (.Clk(clk), .Rst_n(rst_n), .bus(b2));

  typedef struct {
    logic [3:0]  insn;
    logic [23:0] ip;
  } exp_t;

  exp_t        sbq[$];
  logic [3:0]  rom [logic [23:0]];
  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] dlog = 0;
  logic [11:0] dlast = 0;
  bit          mon_prev = 1'b1;

  function automatic logic [3:0] rd(input logic [23:0] a);
    return rom.exists(a) ? rom[a] : OP_NOP;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // ROM models: answer LAT cycles after each fetch pulse
  initial begin
    logic [23:0] a;
    b1.RomReady = 1'b0;
    b1.RomData  = '0;
    forever begin
      @(negedge clk);
      if (b1.RomReq) begin
        a = b1.RomAddr;
        repeat (LAT) @(negedge clk);
        b1.RomData  = rd(a);
        b1.RomReady = 1'b1;
        @(negedge clk);
        b1.RomReady = 1'b0;
      end
    end
  end

  initial begin
    logic [23:0] a;
    b2.RomReady = 1'b0;
    b2.RomData  = '0;
    forever begin
      @(negedge clk);
      if (b2.RomReq) begin
        a = b2.RomAddr;
        repeat (LAT) @(negedge clk);
        b2.RomData  = rd(a);
        b2.RomReady = 1'b1;
        @(negedge clk);
        b2.RomReady = 1'b0;
      end
    end
  end

  // Monitor: each Ready rise pops one expected result
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        mon_prev = 1'b1;
      end else begin
        if (b1.Ready && !mon_prev) begin
          if (sbq.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_ready: got ip %0h expected none",
                     b1.IpAddr);
          end else begin
            e = sbq.pop_front();
            chk("sb_insn", 32'(b1.Insn), 32'(e.insn));
            chk("sb_ip", 32'(b1.IpAddr), 32'(e.ip));
            chk("sb_depth", 32'(b1.LoopDepth), 32'd0);
          end
        end
        mon_prev = b1.Ready;
      end
    end
  end

  // Depth trace: one nibble per change of LoopDepth
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        dlast = '0;
      end else if (b1.LoopDepth != dlast) begin
        dlog  = (dlog << 4) | 32'(b1.LoopDepth[3:0]);
        dlast = b1.LoopDepth;
      end
    end
  end

  task automatic op(input logic ld, input logic [23:0] addr,
                    input logic z, input logic [3:0] ei,
                    input logic [23:0] eip, input logic [31:0] edl,
                    input int elat);
    int n;
    bit low;
    sbq.push_back('{insn: ei, ip: eip});
    dlog = 0;
    b1.Load = ld;
    b1.LoadAddr = addr;
    b1.DataIsZeroed = z;
    b1.Request = 1'b1;
    n = 0;
    low = 1'b0;
    while (n < 500) begin
      @(negedge clk);
      n++;
      if (!b1.Ready) low = 1'b1;
      else if (low) break;
    end
    chk("op_done", 32'(low & b1.Ready), 32'd1);
    if (elat > 0) chk("op_latency", 32'(n), 32'(elat));
    chk("op_depth_trace", dlog, edl);
    b1.Request = 1'b0;
    b1.Load = 1'b0;
    b1.DataIsZeroed = 1'b0;
    @(negedge clk);
  endtask

  task automatic chk_reset();
    chk("rst_ip", 32'(b1.IpAddr), 32'd0);
    chk("rst_depth", 32'(b1.LoopDepth), 32'd0);
    chk("rst_insn", 32'(b1.Insn), 32'd0);
    chk("rst_romreq", 32'(b1.RomReq), 32'd0);
    chk("rst_error", 32'(b1.Error), 32'd0);
    chk("rst_ready", 32'(b1.Ready), 32'd1);
  endtask

  initial begin
    int n;
    b1.Request = 0; b1.Load = 0; b1.DataIsZeroed = 0;
    b1.LoadAddr = '0;
    b2.Request = 0; b2.Load = 0; b2.DataIsZeroed = 0;
    b2.LoadAddr = '0;
    repeat (3) @(negedge clk);
    chk_reset();
    rst_n = 1'b1;
    @(negedge clk);

    // "+[-]>": primed fetch, step, forward skip, step
    rom[24'h0] = OP_INC; rom[24'h1] = OP_OPN;
    rom[24'h2] = OP_DEC; rom[24'h3] = OP_CLS;
    rom[24'h4] = OP_RGT;
    op(0, 0, 0, OP_INC, 24'h0, 32'h0, LAT + 2);
    op(0, 0, 0, OP_OPN, 24'h1, 32'h0, SD + LAT + 2);
    op(0, 0, 1, OP_CLS, 24'h3, 32'h10, 0);
    op(0, 0, 1, OP_RGT, 24'h4, 32'h0, SD + LAT + 2);

    // "[[-]]+": backward lookup from the outer ']'
    rom[24'h0] = OP_OPN; rom[24'h1] = OP_OPN;
    rom[24'h2] = OP_DEC; rom[24'h3] = OP_CLS;
    rom[24'h4] = OP_CLS; rom[24'h5] = OP_INC;
    op(1, 24'h4, 0, OP_CLS, 24'h4, 32'h0, LAT + 2);
    op(0, 0, 0, OP_OPN, 24'h0, 32'h1210, 0);

    // Absolute load, then BCD carry on step
    rom[24'h129] = OP_DEC; rom[24'h130] = OP_RGT;
    op(1, 24'h000129, 0, OP_DEC, 24'h129, 32'h0, 0);
    op(0, 0, 0, OP_RGT, 24'h130, 32'h0, 0);

    // Silent wrap outside lookup
    rom[24'h999999] = OP_INC; rom[24'h0] = OP_OUT;
    op(1, 24'h999999, 0, OP_INC, 24'h999999, 32'h0, 0);
    op(0, 0, 0, OP_OUT, 24'h0, 32'h0, 0);
    chk("wrap_no_error", 32'(b1.Error), 32'd0);

    // Unmatched '[' at 999998 wraps during lookup
    rom[24'h999998] = OP_OPN;
    op(1, 24'h999998, 0, OP_OPN, 24'h999998, 32'h0, 0);
    b1.DataIsZeroed = 1'b1;
    b1.Request = 1'b1;
    n = 0;
    while (!b1.Error && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("wrap_error", 32'(b1.Error), 32'd1);
    chk("wrap_err_ready", 32'(b1.Ready), 32'd0);
    repeat (5) @(negedge clk);
    chk("err_sticky", 32'(b1.Error), 32'd1);
    chk("err_romreq", 32'(b1.RomReq), 32'd0);
    b1.Request = 1'b0;
    b1.DataIsZeroed = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk_reset();
    rst_n = 1'b1;
    @(negedge clk);

    // Reset asserted while a step is in progress
    op(1, 24'h000129, 0, OP_DEC, 24'h129, 32'h0, 0);
    b1.Request = 1'b1;
    repeat (2) @(negedge clk);
    chk("midstep_busy", 32'(b1.Ready), 32'd0);
    rst_n = 1'b0;
    #1;
    chk_reset();
    b1.Request = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // One-digit depth counter: ten nested '[' overflow it
    for (int i = 0; i < 10; i++) rom[24'(i)] = OP_OPN;
    b2.Request = 1'b1;
    n = 0;
    while (n < 50) begin
      @(negedge clk);
      n++;
      if (n > 1 && b2.Ready) break;
    end
    chk("d2_prime_insn", 32'(b2.Insn), 32'(OP_OPN));
    chk("d2_prime_ip", 32'(b2.IpAddr), 32'd0);
    b2.Request = 1'b0;
    @(negedge clk);
    b2.DataIsZeroed = 1'b1;
    b2.Request = 1'b1;
    n = 0;
    while (!b2.Error && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk("d2_ovf_error", 32'(b2.Error), 32'd1);
    chk("d2_ovf_ready", 32'(b2.Ready), 32'd0);
    chk("d2_ovf_depth", 32'(b2.LoopDepth), 32'h9);
    chk("d1_untouched", 32'(b1.Error), 32'd0);
    b2.Request = 1'b0;
    repeat (2) @(negedge clk);
    chk("sb_drained", 32'(sbq.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end
endmodule
